// File: rtl/score_counter.sv
// score_counter
//   Two-player 3-digit BCD score keeper with sticky bonus and rollover flags
//   and a combinational single-digit display mux.
//
// Ports
//   CLK_DRV     in   system clock, rising edge
//   RESET_N     in   asynchronous active-low reset
//   COUNT_1/2   in   score pulse levels; each 0->1 transition adds one point
//   START_GAME  in   synchronous clear of scores and flags (beats score events)
//   PLAYER_SEL  in   display player (0 = P1, 1 = P2)
//   DIGIT_SEL   in   display digit (0 units, 1 tens, 2 hundreds, 3 blank)
//   DIGIT       out  selected BCD digit, 4'hF when blank
//   SCORE_1/2   out  packed BCD score {hundreds, tens, units}
//   BONUS_1/2   out  sticky: score reached BONUS_SCORE
//   ROLL_1/2    out  sticky: score wrapped 999 -> 000 (only if WRAP_FLAG_EN)
module score_counter #(
    parameter logic [11:0] BONUS_SCORE  = 12'h300,
    parameter logic        WRAP_FLAG_EN = 1'b1
) (
    input  logic        CLK_DRV,
    input  logic        RESET_N,
    input  logic        COUNT_1,
    input  logic        COUNT_2,
    input  logic        START_GAME,
    input  logic        PLAYER_SEL,
    input  logic [1:0]  DIGIT_SEL,
    output logic [3:0]  DIGIT,
    output logic [11:0] SCORE_1,
    output logic [11:0] SCORE_2,
    output logic        BONUS_1,
    output logic        BONUS_2,
    output logic        ROLL_1,
    output logic        ROLL_2
);

    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        evt;
    logic [1:0][11:0]  score_q, score_d;
    logic [1:0][11:0]  inc;
    logic [1:0]        wrap;
    logic [1:0]        bonus_q, bonus_d;
    logic [1:0]        roll_q, roll_d;
    logic [11:0]       disp;

    // Returns {wrap, next}; input is always valid BCD so only 9 needs a carry.
    function automatic logic [12:0] bcd_inc(input logic [11:0] v);
        logic [3:0] u, t, h;
        logic       w;
        u = v[3:0];
        t = v[7:4];
        h = v[11:8];
        w = 1'b0;
        if (u == 4'd9) begin
            u = 4'd0;
            if (t == 4'd9) begin
                t = 4'd0;
                if (h == 4'd9) begin
                    h = 4'd0;
                    w = 1'b1;
                end else begin
                    h = h + 4'd1;
                end
            end else begin
                t = t + 4'd1;
            end
        end else begin
            u = u + 4'd1;
        end
        return {w, h, t, u};
    endfunction

    always_comb begin
        // The edge-detect samples track the inputs even during START_GAME,
        // so a pulse that rises under the clear is never counted later.
        cnt_d   = {COUNT_2, COUNT_1};
        evt     = cnt_d & ~cnt_q;
        score_d = score_q;
        bonus_d = bonus_q;
        roll_d  = roll_q;
        inc     = '0;
        wrap    = '0;
        for (int unsigned p = 0; p < 2; p++) begin
            {wrap[p], inc[p]} = bcd_inc(score_q[p]);
            if (START_GAME) begin
                score_d[p] = '0;
                bonus_d[p] = 1'b0;
                roll_d[p]  = 1'b0;
            end else if (evt[p]) begin
                score_d[p] = inc[p];
                // Valid BCD orders the same as binary, so a plain compare works.
                if (inc[p] >= BONUS_SCORE) begin
                    bonus_d[p] = 1'b1;
                end
                if (wrap[p] && WRAP_FLAG_EN) begin
                    roll_d[p] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK_DRV or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q   <= '1;
            score_q <= '0;
            bonus_q <= '0;
            roll_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            score_q <= score_d;
            bonus_q <= bonus_d;
            roll_q  <= roll_d;
        end
    end

    always_comb begin
        disp = PLAYER_SEL ? score_q[1] : score_q[0];
        case (DIGIT_SEL)
            2'd0:    DIGIT = disp[3:0];
            2'd1:    DIGIT = disp[7:4];
            2'd2:    DIGIT = disp[11:8];
            default: DIGIT = 4'hF;
        endcase
    end

    assign SCORE_1 = score_q[0];
    assign SCORE_2 = score_q[1];
    assign BONUS_1 = bonus_q[0];
    assign BONUS_2 = bonus_q[1];
    assign ROLL_1  = roll_q[0];
    assign ROLL_2  = roll_q[1];

endmodule
